// File: rtl/placar_scan_decoder.sv
// Decodes the multiplexed scoreboard 7-segment scan back into score/shot-clock BCD and binary values.
// Optional CHANGE_ONLY_EN: suppress frame_valid for frames identical to the values already published.
module placar_scan_decoder #(
    parameter int SETTLE       = 4,
    parameter int STALE_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] blocos,
    input  logic [6:0] saida,
    output logic [7:0] placar_bcd,
    output logic [7:0] cronos_bcd,
    output logic [6:0] placar_bin,
    output logic [6:0] cronos_bin,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       stale
);

    localparam logic [7:0] SETTLE_C = 8'(SETTLE);
    localparam int         SW       = $clog2(STALE_CYCLES + 1);
    localparam logic [SW-1:0] STALE_C = SW'(STALE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_SETTLING, S_CAPTURED} state_t;

    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
        return ({3'b000, tens} * 7'd10) + {3'b000, units};
    endfunction

    logic [3:0]       blocos_q, pat_q;
    logic [6:0]       saida_q;
    state_t           state_q, state_d;
    logic [7:0]       dwell_q, dwell_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0][3:0]  shadow_q, shadow_d;
    logic [7:0]       placar_bcd_q, cronos_bcd_q;
    logic [6:0]       placar_bin_q, cronos_bin_q;
    logic             frame_valid_q, frame_valid_d;
    logic             seg_err_q, seg_err_d;
    logic [SW-1:0]    stale_cnt_q, stale_cnt_d;

    logic       one_hot, sample, seg_ok, frame_done;
    logic [1:0] idx;
    logic [3:0] seg_val;
    logic [6:0] lit;
    logic [7:0] placar_new, cronos_new;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        one_hot = 1'b1;
        idx     = 2'd0;
        case (blocos_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    assign lit = ~saida_q;

    always_comb begin
        seg_ok  = 1'b1;
        seg_val = 4'd0;
        case (lit)
            7'h3F: seg_val = 4'd0;
            7'h06: seg_val = 4'd1;
            7'h5B: seg_val = 4'd2;
            7'h4F: seg_val = 4'd3;
            7'h66: seg_val = 4'd4;
            7'h6D: seg_val = 4'd5;
            7'h7D: seg_val = 4'd6;
            7'h07: seg_val = 4'd7;
            7'h7F: seg_val = 4'd8;
            7'h6F: seg_val = 4'd9;
            default: seg_ok = 1'b0;
        endcase
    end

    // Dwell FSM: a new one-hot pattern counts as cycle 1, so SETTLE==1 samples immediately.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        sample  = 1'b0;
        if (!one_hot) begin
            state_d = S_IDLE;
            dwell_d = 8'd0;
        end else if (state_q == S_IDLE || blocos_q != pat_q) begin
            dwell_d = 8'd1;
            state_d = S_SETTLING;
            if (SETTLE_C == 8'd1) begin
                sample  = 1'b1;
                state_d = S_CAPTURED;
            end
        end else if (state_q == S_SETTLING) begin
            dwell_d = dwell_q + 8'd1;
            if (dwell_d == SETTLE_C) begin
                sample  = 1'b1;
                state_d = S_CAPTURED;
            end
        end
    end

    always_comb begin
        shadow_d   = shadow_q;
        mask_d     = mask_q;
        seg_err_d  = seg_err_q;
        frame_done = 1'b0;
        if (sample) begin
            if (seg_ok) begin
                shadow_d[idx] = seg_val;
                mask_d[idx]   = 1'b1;
            end else begin
                seg_err_d = 1'b1;
            end
        end
        if (mask_d == 4'hF) begin
            frame_done = 1'b1;
            mask_d     = 4'h0;
        end
        placar_new = {shadow_d[0], shadow_d[1]};
        cronos_new = {shadow_d[2], shadow_d[3]};
`ifdef CHANGE_ONLY_EN
        frame_valid_d = frame_done && (placar_new != placar_bcd_q || cronos_new != cronos_bcd_q);
`else
        frame_valid_d = frame_done;
`endif
        if (frame_done)
            stale_cnt_d = '0;
        else if (stale_cnt_q != STALE_C)
            stale_cnt_d = stale_cnt_q + SW'(1);
        else
            stale_cnt_d = stale_cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            blocos_q      <= 4'hF;
            saida_q       <= 7'h7F;
            pat_q         <= 4'hF;
            state_q       <= S_IDLE;
            dwell_q       <= 8'd0;
            mask_q        <= 4'h0;
            // NOTE: the shadow digits are a tiny register file, reset so a discarded partial frame leaves no residue.
            shadow_q      <= '0;
            placar_bcd_q  <= 8'h00;
            cronos_bcd_q  <= 8'h00;
            placar_bin_q  <= 7'd0;
            cronos_bin_q  <= 7'd0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            stale_cnt_q   <= '0;
        end else begin
            blocos_q      <= blocos;
            saida_q       <= saida;
            pat_q         <= blocos_q;
            state_q       <= state_d;
            dwell_q       <= dwell_d;
            mask_q        <= mask_d;
            shadow_q      <= shadow_d;
            frame_valid_q <= frame_valid_d;
            seg_err_q     <= seg_err_d;
            stale_cnt_q   <= stale_cnt_d;
            if (frame_done) begin
                placar_bcd_q <= placar_new;
                cronos_bcd_q <= cronos_new;
                placar_bin_q <= bcd_to_bin(placar_new[7:4], placar_new[3:0]);
                cronos_bin_q <= bcd_to_bin(cronos_new[7:4], cronos_new[3:0]);
            end
        end
    end

    assign placar_bcd  = placar_bcd_q;
    assign cronos_bcd  = cronos_bcd_q;
    assign placar_bin  = placar_bin_q;
    assign cronos_bin  = cronos_bin_q;
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;
    assign stale       = (stale_cnt_q == STALE_C);

endmodule

// File: tb/tb_placar_scan_decoder.sv
// Self-checking bench for placar_scan_decoder: directed scans plus random dwells against a dwell-level model.
module tb_placar_scan_decoder;
    localparam int SETTLE = 4;
    localparam int STALE  = 64;
    localparam int INF    = 32'h7fffffff;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] blocos = 4'hF;
    logic [6:0] saida = 7'h7F;
    logic [7:0] placar_bcd, cronos_bcd;
    logic [6:0] placar_bin, cronos_bin;
    logic       frame_valid, seg_err, stale;

    placar_scan_decoder #(.SETTLE(SETTLE), .STALE_CYCLES(STALE)) dut (
        .clk(clk), .reset(reset), .blocos(blocos), .saida(saida),
        .placar_bcd(placar_bcd), .cronos_bcd(cronos_bcd),
        .placar_bin(placar_bin), .cronos_bin(cronos_bin),
        .frame_valid(frame_valid), .seg_err(seg_err), .stale(stale)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Digit shapes as lists of lit segment letters.
    string digits_s[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    function automatic logic [6:0] lit_of(input string s);
        logic [6:0] r = '0;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
        return r;
    endfunction

    function automatic logic [6:0] pins_of(input int d);
        return ~lit_of(digits_s[d]);
    endfunction

    function automatic int decode(input logic [6:0] sa);
        for (int d = 0; d < 10; d++) if (pins_of(d) == sa) return d;
        return -1;
    endfunction

    typedef struct { logic [7:0] pl; logic [7:0] cr; int at; } frame_t;
    frame_t exp_q[$];
    int     done_q[$];

    logic [3:0] m_sh[4];
    logic [3:0] m_mask;
    logic [7:0] pub_pl, pub_cr, cur_pl, cur_cr;
    int         err_at, last_zero;
    bit         mon_en = 1'b0;
    logic [3:0] last_en = 4'hF;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
        m_mask = 4'h0;
        pub_pl = 8'h00; pub_cr = 8'h00;
        cur_pl = 8'h00; cur_cr = 8'h00;
        err_at = INF;
        exp_q.delete();
        done_q.delete();
    endtask

    // One dwell as seen at the pins: captured only if exactly one enable is low for >= SETTLE cycles.
    task automatic model_dwell(input logic [3:0] en, input logic [6:0] sa, input int len, input int start);
        int d, v, at;
        logic [7:0] pl, cr;
        bit push;
        if ($countones(~en) != 1 || len < SETTLE) return;
        d = 0;
        for (int i = 0; i < 4; i++) if (!en[i]) d = i;
        v  = decode(sa);
        at = start + SETTLE + 1;
        if (v < 0) begin
            if (err_at == INF) err_at = at;
            return;
        end
        m_sh[d]   = 4'(v);
        m_mask[d] = 1'b1;
        if (m_mask == 4'hF) begin
            m_mask = 4'h0;
            pl = {m_sh[0], m_sh[1]};
            cr = {m_sh[2], m_sh[3]};
            done_q.push_back(at);
            push = 1'b1;
`ifdef CHANGE_ONLY_EN
            push = (pl != pub_pl) || (cr != pub_cr);
`endif
            if (push) exp_q.push_back('{pl, cr, at});
            pub_pl = pl; pub_cr = cr;
        end
    endtask

    // Called just after a rising edge; holds the pins for len cycles.
    task automatic dwell(input logic [3:0] en, input logic [6:0] sa, input int len);
        blocos = en; saida = sa; last_en = en;
        model_dwell(en, sa, len, cyc);
        repeat (len) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [7:0] pl, input logic [7:0] cr, input int len);
        dwell(4'b0111, pins_of(int'(cr[3:0])), len);
        dwell(4'b1011, pins_of(int'(cr[7:4])), len);
        dwell(4'b1101, pins_of(int'(pl[3:0])), len);
        dwell(4'b1110, pins_of(int'(pl[7:4])), len);
    endtask

    task automatic do_reset(input int n);
        mon_en = 1'b0;
        reset = 1'b1; blocos = 4'hF; saida = 7'h7F; last_en = 4'hF;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        last_zero = cyc;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_fv;
            if (done_q.size() != 0 && done_q[0] == cyc) begin
                last_zero = cyc;
                void'(done_q.pop_front());
            end
            exp_fv = (exp_q.size() != 0 && exp_q[0].at == cyc);
            if (exp_fv) begin
                cur_pl = exp_q[0].pl;
                cur_cr = exp_q[0].cr;
                void'(exp_q.pop_front());
            end
            check("frame_valid", 32'(frame_valid), 32'(exp_fv));
            check("placar_bcd", 32'(placar_bcd), 32'(cur_pl));
            check("cronos_bcd", 32'(cronos_bcd), 32'(cronos_bcd === 8'hxx ? 8'h00 : cur_cr));
            check("placar_bin", 32'(placar_bin), int'(cur_pl[7:4]) * 10 + int'(cur_pl[3:0]));
            check("cronos_bin", 32'(cronos_bin), int'(cur_cr[7:4]) * 10 + int'(cur_cr[3:0]));
            check("seg_err", 32'(seg_err), 32'(cyc >= err_at));
            check("stale", 32'(stale), 32'((cyc - last_zero) >= STALE));
        end
    end

    initial begin
        logic [3:0] en;
        logic [6:0] sa;
        int r;

        do_reset(3);

        // Basic frame: score 57, clock 14.
        scan(8'h57, 8'h14, 8);

        // Short dwell on digit 1 is ignored; a SETTLE-long dwell is captured.
        dwell(4'b0111, pins_of(1), 8);
        dwell(4'b1011, pins_of(2), 8);
        dwell(4'b1110, pins_of(3), 8);
        dwell(4'b1101, pins_of(8), 3);
        dwell(4'b1111, 7'h7F, 1);
        dwell(4'b1101, pins_of(8), 4);

        // Overlapping enables produce no capture.
        dwell(4'b0011, pins_of(0), 20);
        scan(8'h62, 8'h09, 6);

        // Undecodable pattern (cdefg) on score units sets the sticky error and blocks the frame.
        dwell(4'b0111, pins_of(7), 6);
        dwell(4'b1011, pins_of(3), 6);
        dwell(4'b1110, pins_of(4), 6);
        dwell(4'b1101, ~lit_of("cdefg"), 6);
        dwell(4'b0111, pins_of(6), 6);
        dwell(4'b1101, pins_of(5), 6);

        // Random dwells, lengths, enable patterns and occasional garbage segments.
        for (int k = 0; k < 150; k++) begin
            do begin
                r = $urandom_range(0, 9);
                if (r <= 6)      en = ~(4'b0001 << $urandom_range(0, 3));
                else if (r == 7) en = 4'b1111;
                else if (r == 8) en = 4'($urandom);
                else             en = 4'b0011;
            end while (en == last_en);
            if ($urandom_range(0, 9) == 0) sa = 7'($urandom);
            else                           sa = pins_of($urandom_range(0, 9));
            dwell(en, sa, $urandom_range(1, 10));
        end
        scan(8'h31, 8'h20, 5);

        // Stop scanning long enough to go stale, then resume.
        dwell(4'b1111, 7'h7F, STALE + 16);
        scan(8'h99, 8'h24, 5);
        scan(8'h99, 8'h24, 5);
        scan(8'h99, 8'h24, 5);
        scan(8'h99, 8'h23, 5);

        // Reset in the middle of a frame discards the partial captures.
        dwell(4'b1111, 7'h7F, 3);
        dwell(4'b1110, pins_of(3), 6);
        dwell(4'b1101, pins_of(8), 6);
        dwell(4'b1111, 7'h7F, 2);
        do_reset(2);
        dwell(4'b0111, pins_of(5), 6);
        dwell(4'b1011, pins_of(4), 6);
        dwell(4'b1111, 7'h7F, 4);
        dwell(4'b1110, pins_of(1), 6);
        dwell(4'b1101, pins_of(2), 6);
        dwell(4'b1111, 7'h7F, 10);

        check("frames_pending", exp_q.size(), 0);
        check("dones_pending", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
